// File: rtl/itcm_boot_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : itcm_boot_ctrl
//  Purpose  : UART boot loader for the core's instruction TCM. Receives a
//             framed image (MAGIC, 16-bit little-endian word count N, 4*N
//             payload bytes packed MSB-first, XOR checksum), writes it into
//             the ITCM, then releases the core from reset and hands the ITCM
//             port over to the core's fetch interface.
//  Ports    : clk, rst (async active-high)
//             rx_valid/rx_data          - received UART byte strobe
//             fetch_req/addr/gnt        - core fetch request / grant
//             fetch_rvalid/rdata        - fetch response (1 cycle after gnt)
//             bram_en/we/addr/wdata     - ITCM port (read data 1 cycle later)
//             bram_rdata                - ITCM read data
//             core_rst, boot_done, boot_err - boot status
//  Options  : `define BOOT_TIMEOUT_EN to abort a frame after TIMEOUT_CYCLES
//             cycles without a received byte.
//  Revision : 1.0 - initial release
// ============================================================================
module itcm_boot_ctrl #(
  parameter int          AW             = 14,
  parameter logic [7:0]  MAGIC          = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 1000000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  input  logic          fetch_req,
  input  logic [AW-1:0] fetch_addr,
  output logic          fetch_gnt,
  output logic          fetch_rvalid,
  output logic [31:0]   fetch_rdata,
  output logic          bram_en,
  output logic          bram_we,
  output logic [AW-1:0] bram_addr,
  output logic [31:0]   bram_wdata,
  input  logic [31:0]   bram_rdata,
  output logic          core_rst,
  output logic          boot_done,
  output logic          boot_err
);

  localparam logic [2:0] c_ST_IDLE = 3'd0;
  localparam logic [2:0] c_ST_LEN0 = 3'd1;
  localparam logic [2:0] c_ST_LEN1 = 3'd2;
  localparam logic [2:0] c_ST_DATA = 3'd3;
  localparam logic [2:0] c_ST_CSUM = 3'd4;
  localparam logic [2:0] c_ST_DONE = 3'd5;
  localparam logic [2:0] c_ST_ERR  = 3'd6;

  logic [2:0]    r_state;
  logic [2:0]    w_nstate;

  logic [15:0]   r_len;      // N, word count of the image
  logic [AW:0]   r_wcnt;     // one extra bit so N = 2**AW is representable
  logic [7:0]    r_csum;
  logic [1:0]    r_bcnt;     // byte position inside the current word
  logic [23:0]   r_word;     // first three bytes of the word being assembled
  logic          r_wr_en;
  logic [AW-1:0] r_wr_addr;
  logic [31:0]   r_wr_data;
  logic          r_rvalid;

  logic [15:0]   w_len_new;
  logic          w_len_bad;
  logic          w_last_word;
  logic          w_tmo;

  // Length as it will be once the high byte in LEN1 is latched.
  assign w_len_new   = {rx_data, r_len[7:0]};
  assign w_len_bad   = (w_len_new == 16'd0) || (32'(w_len_new) > 32'(2**AW));
  assign w_last_word = (32'(r_wcnt) + 32'd1) == 32'(r_len);

`ifdef BOOT_TIMEOUT_EN
  localparam int c_TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [c_TW-1:0] r_tmo_cnt;
  logic            w_active;

  assign w_active = (r_state == c_ST_LEN0) || (r_state == c_ST_LEN1) ||
                    (r_state == c_ST_DATA) || (r_state == c_ST_CSUM);
  // Fires on the cycle that completes TIMEOUT_CYCLES idle cycles.
  assign w_tmo    = w_active && !rx_valid &&
                    (r_tmo_cnt == c_TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo_cnt <= '0;
    end else if (!w_active || rx_valid || w_tmo) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + c_TW'(1);
    end
  end
`else
  // No timeout: the FSM waits for bytes indefinitely. The parameter is
  // still referenced so the interface is identical in both builds.
  assign w_tmo = (TIMEOUT_CYCLES < 0);
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_nstate;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_nstate = r_state;
    case (r_state)
      c_ST_IDLE, c_ST_ERR: begin
        if (rx_valid && (rx_data == MAGIC)) w_nstate = c_ST_LEN0;
      end
      c_ST_LEN0: begin
        if (rx_valid) w_nstate = c_ST_LEN1;
      end
      c_ST_LEN1: begin
        if (rx_valid) w_nstate = w_len_bad ? c_ST_ERR : c_ST_DATA;
      end
      c_ST_DATA: begin
        if (rx_valid && (r_bcnt == 2'd3) && w_last_word) w_nstate = c_ST_CSUM;
      end
      c_ST_CSUM: begin
        if (rx_valid) w_nstate = (rx_data == r_csum) ? c_ST_DONE : c_ST_ERR;
      end
      c_ST_DONE: w_nstate = c_ST_DONE;
      default:   w_nstate = c_ST_IDLE;
    endcase
    if (w_tmo) w_nstate = c_ST_ERR;
  end

  // --------------------------------------------------------------------------
  // Loader datapath: length, word packing, checksum, registered ITCM writes
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len     <= '0;
      r_wcnt    <= '0;
      r_csum    <= '0;
      r_bcnt    <= '0;
      r_word    <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_rvalid  <= 1'b0;
    end else begin
      r_wr_en  <= 1'b0;
      r_rvalid <= fetch_gnt;
      if (rx_valid) begin
        case (r_state)
          c_ST_IDLE, c_ST_ERR: begin
            if (rx_data == MAGIC) begin
              r_wcnt <= '0;
              r_csum <= '0;
              r_bcnt <= '0;
              r_len  <= '0;
            end
          end
          c_ST_LEN0: r_len[7:0]  <= rx_data;
          c_ST_LEN1: r_len[15:8] <= rx_data;
          c_ST_DATA: begin
            r_csum <= r_csum ^ rx_data;
            r_bcnt <= r_bcnt + 2'd1;
            case (r_bcnt)
              2'd0: r_word[23:16] <= rx_data;
              2'd1: r_word[15:8]  <= rx_data;
              2'd2: r_word[7:0]   <= rx_data;
              default: begin
                // Word complete: present the write next cycle. The write
                // registers are separate from the byte path so a byte in the
                // following cycle is still accepted.
                r_wr_en   <= 1'b1;
                r_wr_addr <= r_wcnt[AW-1:0];
                r_wr_data <= {r_word, rx_data};
                r_wcnt    <= r_wcnt + (AW+1)'(1);
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: status and ITCM port ownership
  // --------------------------------------------------------------------------
  always_comb begin
    core_rst   = 1'b1;
    boot_done  = 1'b0;
    boot_err   = 1'b0;
    fetch_gnt  = 1'b0;
    bram_en    = r_wr_en;
    bram_we    = r_wr_en;
    bram_addr  = r_wr_addr;
    bram_wdata = r_wr_data;
    case (r_state)
      c_ST_DONE: begin
        core_rst  = 1'b0;
        boot_done = 1'b1;
        fetch_gnt = fetch_req;
        bram_en   = fetch_req;
        bram_we   = 1'b0;
        bram_addr = fetch_addr;
      end
      c_ST_ERR: boot_err = 1'b1;
      default: ;
    endcase
  end

  assign fetch_rvalid = r_rvalid;
  assign fetch_rdata  = bram_rdata;

endmodule
`default_nettype wire
